bus_scan_reader: RTL and testbench

- Read-side controller for the shared 8-bit tri-state bus that our counters drive through their output-enable/data-out pins.
- Scans a masked set of bus sources in ascending index order. For each source it drives that source's output enable one-hot, waits for the bus to settle, samples the bus, releases it, and inserts a turnaround cycle.
- Each sample is tagged with its source index and pushed into a first-word-fall-through FIFO, which is drained through a valid/ready interface.

---
 rtl/bus_scan_reader.sv | 186 ++++++++++++++++++
 tb/tb_bus_scan_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_scan_reader.sv
// bus_scan_reader
//   Read-side controller for the shared 8-bit tri-state counter bus. It walks
//   a latched source mask in ascending index order. For each selected source it
//   drives that source's output enable one-hot, lets the bus settle, samples it,
//   releases it, and inserts a one-cycle turnaround. Each sample is tagged with
//   its source index and queued in a first-word-fall-through FIFO.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   start      one-cycle scan request, honoured only while idle
//   src_mask   sources to scan, captured when start is accepted
//   bus_oe     one-hot (or zero) output enable per source
//   bus_in     shared bus value
//   out_data   FIFO head sample
//   out_src    FIFO head source index
//   out_valid  FIFO non-empty
//   out_ready  consumer takes the head when out_valid && out_ready
//   busy       high whenever a scan is in progress
//   done       one-cycle pulse after the final turnaround of a scan
//   overflow   sticky: src_mask changed while busy (cleared by rst only)
module bus_scan_reader #(
  parameter  int NUM_SRC    = 4,
  parameter  int SETTLE     = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int SRC_W      = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_SRC-1:0] src_mask,
  output logic [NUM_SRC-1:0] bus_oe,
  input  logic [7:0]         bus_in,
  output logic [7:0]         out_data,
  output logic [SRC_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = SRC_W + 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENABLE,
    S_SAMPLE,
    S_GAP
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [NUM_SRC-1:0]   r_mask;
  logic [SRC_W-1:0]     r_idx;
  logic [2:0]           r_cnt;
  logic                 r_done;
  logic                 r_overflow;

  logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr;
  logic [PTR_W-1:0]     r_rd;
  logic [PTR_W:0]       r_count;

  logic                 w_first_hit;
  logic [SRC_W-1:0]     w_first_idx;
  logic                 w_next_hit;
  logic [SRC_W-1:0]     w_next_idx;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;

  // Lowest set bit of the incoming mask (scan entry point).
  always_comb begin
    w_first_hit = 1'b0;
    w_first_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (src_mask[i] && !w_first_hit) begin
        w_first_hit = 1'b1;
        w_first_idx = SRC_W'(i);
      end
    end
  end

  // Next higher set bit of the latched mask above the current index.
  always_comb begin
    w_next_hit = 1'b0;
    w_next_idx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (r_mask[i] && (i > 32'(r_idx)) && !w_next_hit) begin
        w_next_hit = 1'b1;
        w_next_idx = SRC_W'(i);
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push  = (r_state == S_SAMPLE) && (!w_full || w_pop);

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (start && w_first_hit) w_next_state = S_ENABLE;
      S_ENABLE: if (r_cnt == 3'(SETTLE - 1)) w_next_state = S_SAMPLE;
      S_SAMPLE: if (w_push) w_next_state = S_GAP;
      S_GAP:    w_next_state = w_next_hit ? S_ENABLE : S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= (r_state == S_GAP) && !w_next_hit;
      if ((r_state != S_IDLE) && (src_mask != r_mask)) r_overflow <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (start && w_first_hit) begin
            r_mask <= src_mask;
            r_idx  <= w_first_idx;
            r_cnt  <= '0;
          end
        end
        S_ENABLE: r_cnt <= r_cnt + 3'd1;
        S_GAP: begin
          if (w_next_hit) begin
            r_idx <= w_next_idx;
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {r_idx, bus_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // bus_oe is decoded from the registered state so a reset drops it at once.
  always_comb begin
    bus_oe = '0;
    if ((r_state == S_ENABLE) || (r_state == S_SAMPLE))
      bus_oe = NUM_SRC'(1) << r_idx;
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd][7:0];
  assign out_src   = w_empty ? '0 : r_mem[r_rd][ENT_W-1:8];
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_bus_scan_reader.sv
module tb_bus_scan_reader;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // Instance A: SETTLE=1, 2-entry FIFO
  logic       a_start, a_ready, a_valid, a_busy, a_done, a_ovf;
  logic [3:0] a_mask, a_oe;
  logic [7:0] a_bus, a_data;
  logic [1:0] a_src;

  // Instance B: SETTLE=3, 4-entry FIFO
  logic       b_start, b_ready, b_valid, b_busy, b_done, b_ovf;
  logic [3:0] b_mask, b_oe;
  logic [7:0] b_bus, b_data;
  logic [1:0] b_src;
  int         b_age;

  bus_scan_reader #(.NUM_SRC(4), .SETTLE(1), .FIFO_DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .src_mask(a_mask), .bus_oe(a_oe),
    .bus_in(a_bus), .out_data(a_data), .out_src(a_src), .out_valid(a_valid),
    .out_ready(a_ready), .busy(a_busy), .done(a_done), .overflow(a_ovf)
  );

  bus_scan_reader #(.NUM_SRC(4), .SETTLE(3), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .src_mask(b_mask), .bus_oe(b_oe),
    .bus_in(b_bus), .out_data(b_data), .out_src(b_src), .out_valid(b_valid),
    .out_ready(b_ready), .busy(b_busy), .done(b_done), .overflow(b_ovf)
  );

  // Counter sources on bus A: each drives a fixed value when enabled.
  always_comb begin
    a_bus = 8'h00;
    if      (a_oe[0]) a_bus = 8'h11;
    else if (a_oe[1]) a_bus = 8'h22;
    else if (a_oe[2]) a_bus = 8'h33;
    else if (a_oe[3]) a_bus = 8'h44;
  end

  // Bus B: stale value 0x5A until 2 cycles after the enable rises, then A0+index.
  always @(posedge clk) begin
    if (b_oe == 4'b0000) b_age <= 0;
    else                 b_age <= b_age + 1;
  end
  always_comb begin
    b_bus = 8'h5A;
    if (b_oe != 4'b0000 && b_age >= 2) begin
      if      (b_oe[0]) b_bus = 8'hA0;
      else if (b_oe[1]) b_bus = 8'hA1;
      else if (b_oe[2]) b_bus = 8'hA2;
      else              b_bus = 8'hA3;
    end
  end

  int         n_chk = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  int         k;
  int         dcnt;
  int         nact;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called once per cycle: score any pop about to happen and count done pulses.
  task automatic obs_a();
    if (a_valid && a_ready) begin
      if (k < exp_q.size()) chk("a_pop", {22'd0, a_src, a_data}, {22'd0, exp_q[k]});
      k++;
    end
    if (a_done) dcnt++;
  endtask

  logic [3:0] oe_tbl1 [9]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
                               4'b0000, 4'b1000, 4'b1000, 4'b0000};
  logic [3:0] oe_tbl3 [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                               4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_mask = 4'b0000; a_ready = 1'b0;
    b_start = 1'b0; b_mask = 4'b0000; b_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_oe", a_oe, 4'b0000);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_data", a_data, 8'h00);
    chk("rst_src", a_src, 2'd0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_ovf", a_ovf, 1'b0);
    rst = 1'b0;

    // Basic scan, mask 1011
    @(negedge clk);
    a_start = 1'b1; a_mask = 4'b1011; a_ready = 1'b1;
    exp_q = '{10'h011, 10'h122, 10'h344}; k = 0; dcnt = 0;
    @(negedge clk);
    a_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 9) chk($sformatf("basic_oe_c%0d", c), a_oe, oe_tbl1[c-1]);
      if (c == 10) begin
        chk("basic_done_c10", a_done, 1'b1);
        chk("basic_busy_c10", a_busy, 1'b0);
      end
      obs_a();
      @(negedge clk);
    end
    chk("basic_pops", k, 3);
    chk("basic_done_cnt", dcnt, 1);

    // Back-pressure: FIFO fills after two pushes, scan stalls on source 2
    a_ready = 1'b0; a_start = 1'b1; a_mask = 4'b1111;
    exp_q = '{10'h011, 10'h122, 10'h233, 10'h344}; k = 0; dcnt = 0;
    @(negedge clk);
    a_start = 1'b0;
    repeat (11) @(negedge clk);
    chk("bp_stall_oe", a_oe, 4'b0100);
    chk("bp_stall_busy", a_busy, 1'b1);
    chk("bp_stall_valid", a_valid, 1'b1);
    a_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      obs_a();
      @(negedge clk);
    end
    chk("bp_pops", k, 4);
    chk("bp_done_cnt", dcnt, 1);
    chk("bp_ovf", a_ovf, 1'b0);

    // start with an empty mask is ignored
    a_start = 1'b1; a_mask = 4'b0000;
    @(negedge clk);
    a_start = 1'b0;
    nact = 0; dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (a_oe != 4'b0000) nact++;
      if (a_done) dcnt++;
      chk("zmask_busy", a_busy, 1'b0);
      @(negedge clk);
    end
    chk("zmask_oe_cycles", nact, 0);
    chk("zmask_done", dcnt, 0);

    // start while busy is ignored
    a_start = 1'b1; a_mask = 4'b0001;
    exp_q = '{10'h011}; k = 0; dcnt = 0; nact = 0;
    @(negedge clk);
    for (int c = 1; c <= 10; c++) begin
      a_start = (c == 1);
      if (a_oe != 4'b0000) nact++;
      obs_a();
      @(negedge clk);
    end
    chk("busy_start_oe_cycles", nact, 2);
    chk("busy_start_done", dcnt, 1);
    chk("busy_start_pops", k, 1);
    chk("busy_start_ovf", a_ovf, 1'b0);

    // Reset in the SAMPLE cycle of source 1
    a_ready = 1'b0; a_start = 1'b1; a_mask = 4'b1111;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_pre_oe", a_oe, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_oe", a_oe, 4'b0000);
    chk("midrst_valid", a_valid, 1'b0);
    chk("midrst_busy", a_busy, 1'b0);
    rst = 1'b0;
    a_ready = 1'b1; a_start = 1'b1; a_mask = 4'b0100;
    exp_q = '{10'h233}; k = 0; dcnt = 0;
    @(negedge clk);
    a_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      obs_a();
      @(negedge clk);
    end
    chk("midrst_rescan_pops", k, 1);
    chk("midrst_rescan_done", dcnt, 1);

    // Mask change during ENABLE sets overflow; latched mask still used
    a_start = 1'b1; a_mask = 4'b0101;
    exp_q = '{10'h011, 10'h233}; k = 0; dcnt = 0;
    @(negedge clk);
    a_start = 1'b0; a_mask = 4'b1111;
    @(negedge clk);
    chk("ovf_set", a_ovf, 1'b1);
    for (int c = 0; c < 10; c++) begin
      obs_a();
      @(negedge clk);
    end
    chk("ovf_pops", k, 2);
    chk("ovf_done", dcnt, 1);
    chk("ovf_sticky", a_ovf, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("ovf_cleared", a_ovf, 1'b0);
    rst = 1'b0;
    a_mask = 4'b0000;

    // SETTLE=3: bus changes 2 cycles after enable, new value must be sampled
    b_start = 1'b1; b_mask = 4'b0011; b_ready = 1'b1;
    k = 0;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("settle_oe_c%0d", c), b_oe, oe_tbl3[c-1]);
      if (c == 5)  chk("settle_head0", {b_valid, b_src, b_data}, {1'b1, 2'd0, 8'hA0});
      if (c == 10) chk("settle_head1", {b_valid, b_src, b_data}, {1'b1, 2'd1, 8'hA1});
      if (c == 11) begin
        chk("settle_done", b_done, 1'b1);
        chk("settle_busy", b_busy, 1'b0);
      end
      if (b_valid && b_ready) k++;
      @(negedge clk);
    end
    chk("settle_pops", k, 2);
    chk("settle_ovf", b_ovf, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
